conc_stim_player: RTL and testbench
===================================

Name: conc_stim_player

Overview:
- Synthesizable, parametrised stimulus sequencer for concolic test harnesses; the successor of the fixed-width testbench program-counter driver.
- Holds a loadable program of stimulus words and replays them onto a DUT input bus plus display/observe sideband bits, one word per clock.
- Adds HOLD (wait), counted JUMP (loop), HALT, start/stop control and completion status.
- Sits between the harness loader and the DUT top instance.

Parameters:
- DATA_W, 32, width of the driven data bus; must be ≥ ADDR_W+CNT_W.
- DEPTH, 1024, program words; must be a power of two.
- ADDR_W, $clog2(DEPTH), program address width.
- CNT_W, 16, width of the HOLD and loop counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  program write strobe.
- load_addr  in  ADDR_W  program write address.
- load_word  in  DATA_W+4  word written: {cmd[1:0], obs, disp, data}.
- start  in  1  begin execution at address 0.
- stop  in  1  abort execution.
- out_data  out  DATA_W  driven DUT input.
- out_disp  out  1  display sideband.
- out_obs  out  1  observe sideband.
- step  out  1  one-cycle pulse per executed DRIVE.
- pc  out  ADDR_W  current program address.
- busy  out  1  high in RUN or HOLD.
- done  out  1  sticky completion flag.
- wrap_err  out  1  sticky: pc ran past DEPTH-1.

Behaviour:
- Opcodes (cmd field):
  - 00 DRIVE: out_data/out_disp/out_obs <= word fields; step pulses; pc+1.
  - 01 HOLD: C = data[CNT_W-1:0]; outputs unchanged for C further cycles, then pc+1. C=0 behaves as a NOP (pc+1 next cycle).
  - 10 JUMP: T = data[ADDR_W-1:0], N = data[ADDR_W+CNT_W-1:ADDR_W]; body re-executes N extra times (rules below).
  - 11 HALT: go to HALTED; done=1.
- Reset: state IDLE; pc=0; out_data=0; out_disp=0; out_obs=0; step=0; busy=0; done=0; wrap_err=0; loop_active=0; loop_cnt=0; hold_cnt=0. Program memory is not reset.
- Memory: write port synchronous; read is combinational at pc. Each RUN cycle executes mem[pc]; resulting outputs are registered at that edge, so latency is 1 clock from pc to out_*.
- States:
  - IDLE: start -> RUN with pc=0.
  - RUN: executes one word per cycle.
  - HOLD: counts hold_cnt down to 1, then returns to RUN with pc+1.
  - HALTED: start -> RUN with pc=0, clears done and wrap_err.
- JUMP semantics (single shared counter, no nesting):
  - !loop_active and N≠0: loop_cnt<=N-1, loop_active<=1, pc<=T.
  - !loop_active and N=0: pc+1 (no-op).
  - loop_active and loop_cnt≠0: loop_cnt-1, pc<=T.
  - loop_active and loop_cnt=0: loop_active<=0, pc+1.
- Boundary conditions:
  - Wrap: a non-JUMP word at pc=DEPTH-1 that advances sets wrap_err=1 and done=1, enters HALTED, and leaves pc at DEPTH-1.
  - stop in RUN/HOLD: HALTED next edge, done=1, outputs keep last values; stop has priority over the word at pc, which is not executed.
  - stop in IDLE/HALTED: ignored.
  - start while busy: ignored.
  - start and stop in the same cycle from HALTED: stop wins (stay HALTED).
  - load_en: honoured only in IDLE/HALTED; ignored while busy.
  - Reset asserted mid-run: immediate return to reset values.

Decomposition:
- Package conc_stim_pkg:
  - opcode localparams OP_DRIVE/OP_HOLD/OP_JUMP/OP_HALT;
  - state enum (IDLE, RUN, HOLD, HALTED);
  - field-slice helper functions for cmd/obs/disp/data.
- Sub-module conc_stim_mem: DEPTH×(DATA_W+4) array, synchronous write, combinational read.
- The top contains the FSM, pc, hold/loop counters and output registers.

Test Plan:
Every scenario uses DEPTH=16 and DATA_W=32.
1. Load DRIVE 0xA5, DRIVE 0x5A (disp=1), HALT; start -> out_data 0xA5 then 0x5A one cycle later with out_disp=1; step pulses twice; done=1 with pc=2 on the third cycle.
2. DRIVE 0x1; HOLD C=3; DRIVE 0x2; HALT -> 0x1 stays on out_data for 4 cycles, then 0x2; HOLD C=0 variant gives 0x1 for 2 cycles only.
3. Addr0 DRIVE 0x10, addr1 DRIVE 0x11, addr2 JUMP T=0 N=2, addr3 HALT -> sequence 10,11,10,11,10,11; step count 6; loop_active=0 at halt.
4. Sixteen DRIVE words, no HALT -> after the 16th drive, wrap_err=1, done=1, pc=15.
5. stop asserted during a 10-cycle HOLD, on its 4th cycle -> HALTED next edge; out_data unchanged; start then replays from pc=0 and done clears.
6. Reset pulsed mid-loop; load_en pulsed while busy -> all outputs 0 and state IDLE after reset; the program word written while busy is unchanged.

Source files
------------

// File: rtl/conc_stim_pkg.sv
// Shared opcodes, FSM states and program-word field helpers for the stimulus player.
package conc_stim_pkg;

    localparam logic [1:0] OP_DRIVE = 2'b00;
    localparam logic [1:0] OP_HOLD  = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        HALTED
    } state_t;

    // Helpers take the 4-bit header {cmd[1:0], obs, disp} sitting above the data field.
    function automatic logic [1:0] hdr_cmd(input logic [3:0] hdr);
        return hdr[3:2];
    endfunction

    function automatic logic hdr_obs(input logic [3:0] hdr);
        return hdr[1];
    endfunction

    function automatic logic hdr_disp(input logic [3:0] hdr);
        return hdr[0];
    endfunction

endpackage

// File: rtl/conc_stim_mem.sv
// Program store: synchronous write port, combinational read port.
module conc_stim_mem
    import conc_stim_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WORD_W = 36
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/conc_stim_player.sv
// Stimulus sequencer: replays a loaded program of DRIVE/HOLD/JUMP/HALT words onto a DUT bus.
module conc_stim_player
    import conc_stim_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W+3:0] load_word,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_disp,
    output logic              out_obs,
    output logic              step,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              wrap_err
);

    localparam int unsigned       WORD_W  = DATA_W + 4;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [DATA_W-1:0]  data_d;
    logic               disp_d, obs_d, step_d, busy_d, done_d, wrap_d;
    logic               loop_active, loop_active_d;
    logic [CNT_W-1:0]   loop_cnt, loop_cnt_d;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic               adv;

    logic [WORD_W-1:0]  word_c;
    logic [3:0]         hdr_c;
    logic [1:0]         cmd_c;
    logic [DATA_W-1:0]  wdata_c;
    logic [CNT_W-1:0]   hold_len_c, loop_n_c;
    logic [ADDR_W-1:0]  target_c;
    logic               we_c;

    assign we_c = load_en && ((state_q == IDLE) || (state_q == HALTED));

    conc_stim_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk     (clk),
        .we      (we_c),
        .waddr   (load_addr),
        .wdata   (load_word),
        .raddr   (pc),
        .rdata_c (word_c)
    );

    assign hdr_c      = word_c[DATA_W+3:DATA_W];
    assign cmd_c      = hdr_cmd(hdr_c);
    assign wdata_c    = word_c[DATA_W-1:0];
    assign hold_len_c = word_c[CNT_W-1:0];
    assign target_c   = word_c[ADDR_W-1:0];
    assign loop_n_c   = word_c[ADDR_W+CNT_W-1:ADDR_W];

    // Next-state and next-output logic; the HOLD word's own cycle is the first of its C cycles.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        data_d        = out_data;
        disp_d        = out_disp;
        obs_d         = out_obs;
        step_d        = 1'b0;
        done_d        = done;
        wrap_d        = wrap_err;
        loop_active_d = loop_active;
        loop_cnt_d    = loop_cnt;
        hold_cnt_d    = hold_cnt;
        adv           = 1'b0;

        case (state_q)
            IDLE, HALTED: begin
                if (start && !stop) begin
                    state_d       = RUN;
                    pc_d          = '0;
                    done_d        = 1'b0;
                    wrap_d        = 1'b0;
                    loop_active_d = 1'b0;
                    loop_cnt_d    = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else begin
                    case (cmd_c)
                        OP_DRIVE: begin
                            data_d = wdata_c;
                            disp_d = hdr_disp(hdr_c);
                            obs_d  = hdr_obs(hdr_c);
                            step_d = 1'b1;
                            adv    = 1'b1;
                        end
                        OP_HOLD: begin
                            if (hold_len_c <= CNT_W'(1)) begin
                                adv = 1'b1;
                            end else begin
                                hold_cnt_d = hold_len_c - CNT_W'(1);
                                state_d    = HOLD;
                            end
                        end
                        OP_JUMP: begin
                            if (!loop_active) begin
                                if (loop_n_c != '0) begin
                                    loop_cnt_d    = loop_n_c - CNT_W'(1);
                                    loop_active_d = 1'b1;
                                    pc_d          = target_c;
                                end else begin
                                    pc_d = pc + ADDR_W'(1);
                                end
                            end else if (loop_cnt != '0) begin
                                loop_cnt_d = loop_cnt - CNT_W'(1);
                                pc_d       = target_c;
                            end else begin
                                loop_active_d = 1'b0;
                                pc_d          = pc + ADDR_W'(1);
                            end
                        end
                        default: begin
                            state_d = HALTED;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end else if (hold_cnt <= CNT_W'(1)) begin
                    adv = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Sequential advance; stepping off the last address halts with wrap_err instead.
        if (adv) begin
            if (pc == LAST_PC) begin
                wrap_d  = 1'b1;
                done_d  = 1'b1;
                state_d = HALTED;
            end else begin
                pc_d    = pc + ADDR_W'(1);
                state_d = RUN;
            end
        end

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc          <= '0;
            out_data    <= '0;
            out_disp    <= 1'b0;
            out_obs     <= 1'b0;
            step        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap_err    <= 1'b0;
            loop_active <= 1'b0;
            loop_cnt    <= '0;
            hold_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            pc          <= pc_d;
            out_data    <= data_d;
            out_disp    <= disp_d;
            out_obs     <= obs_d;
            step        <= step_d;
            busy        <= busy_d;
            done        <= done_d;
            wrap_err    <= wrap_d;
            loop_active <= loop_active_d;
            loop_cnt    <= loop_cnt_d;
            hold_cnt    <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_conc_stim_player.sv
// Self-checking bench for conc_stim_player against an instruction-level program interpreter.
module tb_conc_stim_player;
    import conc_stim_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [35:0] load_word = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] out_data;
    logic        out_disp, out_obs, step;
    logic [3:0]  pc;
    logic        busy, done, wrap_err;

    conc_stim_player #(
        .DATA_W (32),
        .DEPTH  (16),
        .ADDR_W (4),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_word (load_word),
        .start     (start),
        .stop      (stop),
        .out_data  (out_data),
        .out_disp  (out_disp),
        .out_obs   (out_obs),
        .step      (step),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .wrap_err  (wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        disp;
        logic        obs;
        logic        step;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
        logic        wrap;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        obs_q[$];
    logic [35:0] prog [16];
    logic [31:0] m_data;
    logic        m_disp, m_obs, m_lact;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [35:0] w_drive(input logic [31:0] d, input logic dp, input logic ob);
        return {2'b00, ob, dp, d};
    endfunction
    function automatic logic [35:0] w_hold(input int c);
        return {2'b01, 2'b00, 16'h0, 16'(c)};
    endfunction
    function automatic logic [35:0] w_jump(input int t, input int n);
        return {2'b10, 2'b00, 12'h0, 16'(n), 4'(t)};
    endfunction
    function automatic logic [35:0] w_halt();
        return {2'b11, 34'h0};
    endfunction

    task automatic push_exp(input int p, input bit st, input bit bz, input bit dn, input bit wr);
        exp_t e;
        e.data = m_data; e.disp = m_disp; e.obs = m_obs;
        e.step = st; e.pc = 4'(p); e.busy = bz; e.done = dn; e.wrap = wr;
        exp_q.push_back(e);
    endtask

    task automatic advance(inout int p, inout bit f, input bit st);
        if (p == 15) begin
            push_exp(15, st, 1'b0, 1'b1, 1'b1);
            f = 1'b1;
        end else begin
            p++;
            push_exp(p, st, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Interprets prog[] one instruction at a time, emitting the expected post-edge trace.
    task automatic run_model(input int stop_at, input int max_cyc);
        int mpc, lcnt, n, tgt, cnt;
        bit lact, fin;
        logic [35:0] w;
        logic [31:0] d;
        exp_t last;
        exp_q.delete();
        mpc = 0; lact = 0; lcnt = 0; fin = 0;
        push_exp(0, 1'b0, 1'b1, 1'b0, 1'b0);
        while (!fin && exp_q.size() < max_cyc) begin
            w = prog[mpc];
            d = w[31:0];
            case (w[35:34])
                2'd0: begin
                    m_data = d; m_obs = w[33]; m_disp = w[32];
                    advance(mpc, fin, 1'b1);
                end
                2'd1: begin
                    n = (d[15:0] == 16'h0) ? 1 : int'(d[15:0]);
                    for (int k = 1; k < n; k++) push_exp(mpc, 1'b0, 1'b1, 1'b0, 1'b0);
                    advance(mpc, fin, 1'b0);
                end
                2'd2: begin
                    tgt = int'(d[3:0]);
                    cnt = int'(d[19:4]);
                    if (!lact && cnt != 0) begin
                        lact = 1; lcnt = cnt - 1; mpc = tgt;
                    end else if (lact && lcnt != 0) begin
                        lcnt--; mpc = tgt;
                    end else begin
                        lact = 0; mpc = (mpc + 1) % 16;
                    end
                    push_exp(mpc, 1'b0, 1'b1, 1'b0, 1'b0);
                end
                default: begin
                    push_exp(mpc, 1'b0, 1'b0, 1'b1, 1'b0);
                    fin = 1;
                end
            endcase
        end
        m_lact = lact;
        // A stop freezes everything at the previous cycle's values and raises done.
        if (stop_at >= 1 && stop_at < exp_q.size()) begin
            last = exp_q[stop_at-1];
            while (exp_q.size() > stop_at) void'(exp_q.pop_back());
            m_data = last.data; m_disp = last.disp; m_obs = last.obs;
            last.step = 1'b0; last.busy = 1'b0; last.done = 1'b1; last.wrap = 1'b0;
            exp_q.push_back(last);
        end
    endtask

    task automatic play(input int stop_at, input int max_cyc, input bit rnd_start);
        run_model(stop_at, max_cyc);
        obs_q.delete();
        start = 1'b1;
        stop  = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            start = rnd_start && (i + 1 < exp_q.size()) && ($urandom_range(0, 1) == 1);
            stop  = (i + 1 == stop_at);
            obs_q.push_back({out_data, out_disp, out_obs, step, pc, busy, done, wrap_err});
        end
        start = 1'b0;
        stop  = 1'b0;
        if (busy) begin
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; load_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_data = '0; m_disp = 1'b0; m_obs = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 4'(i); load_word = prog[i];
            @(posedge clk); #1;
        end
        load_en = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) prog[i] = w_halt();
    endtask

    task automatic test_reset();
        exp_t o;
        #1;
        o = {out_data, out_disp, out_obs, step, pc, busy, done, wrap_err};
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got %h want 0", o);
        end
        do_reset();
    endtask

    task automatic test_drive();
        int steps;
        do_reset();
        fill_halt();
        prog[0] = w_drive(32'hA5, 1'b0, 1'b0);
        prog[1] = w_drive(32'h5A, 1'b1, 1'b0);
        load_all();
        play(-1, 50, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL drive_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() < 4 || obs_q[1].data !== 32'hA5 || obs_q[2].data !== 32'h5A
            || obs_q[2].disp !== 1'b1 || obs_q[3].done !== 1'b1 || obs_q[3].pc !== 4'd2) begin
            n_bad++;
            $display("FAIL drive_fixed: got %0d cycles, want A5,5A(disp),done@pc2", obs_q.size());
        end
        steps = 0;
        foreach (obs_q[i]) steps += int'(obs_q[i].step);
        n_cmp++;
        if (steps != 2) begin
            n_bad++;
            $display("FAIL drive_steps: got %0d want 2", steps);
        end
    endtask

    task automatic test_hold();
        int ones;
        int c_vals[2] = '{3, 0};
        int want[2]   = '{4, 2};
        for (int v = 0; v < 2; v++) begin
            do_reset();
            fill_halt();
            prog[0] = w_drive(32'h1, 1'b0, 1'b1);
            prog[1] = w_hold(c_vals[v]);
            prog[2] = w_drive(32'h2, 1'b1, 1'b0);
            load_all();
            play(-1, 50, 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL hold_trace C=%0d cyc %0d: got %h want %h", c_vals[v], i, obs_q[i], exp_q[i]);
                end
            end
            ones = 0;
            foreach (obs_q[i]) if (obs_q[i].data == 32'h1) ones++;
            n_cmp++;
            if (ones != want[v]) begin
                n_bad++;
                $display("FAIL hold_len C=%0d: got %0d cycles want %0d", c_vals[v], ones, want[v]);
            end
        end
    endtask

    task automatic test_loop();
        logic [31:0] seq[$];
        logic [31:0] want_seq[6] = '{32'h10, 32'h11, 32'h10, 32'h11, 32'h10, 32'h11};
        do_reset();
        fill_halt();
        prog[0] = w_drive(32'h10, 1'b0, 1'b0);
        prog[1] = w_drive(32'h11, 1'b0, 1'b0);
        prog[2] = w_jump(0, 2);
        load_all();
        play(-1, 60, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL loop_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        foreach (obs_q[i]) if (obs_q[i].step) seq.push_back(obs_q[i].data);
        n_cmp++;
        if (seq.size() != 6) begin
            n_bad++;
            $display("FAIL loop_steps: got %0d want 6", seq.size());
        end
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            n_cmp++;
            if (seq[i] !== want_seq[i]) begin
                n_bad++;
                $display("FAIL loop_seq[%0d]: got %h want %h", i, seq[i], want_seq[i]);
            end
        end
        n_cmp++;
        if (dut.loop_active !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_active_at_halt: got %b want 0", dut.loop_active);
        end
    endtask

    task automatic test_wrap();
        exp_t last;
        do_reset();
        for (int i = 0; i < 16; i++)
            prog[i] = w_drive($urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        load_all();
        play(-1, 60, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL wrap_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        last = obs_q[obs_q.size()-1];
        n_cmp++;
        if (last.wrap !== 1'b1 || last.done !== 1'b1 || last.pc !== 4'd15 || last.busy !== 1'b0
            || last.data !== prog[15][31:0]) begin
            n_bad++;
            $display("FAIL wrap_final: got %h want wrap=1 done=1 pc=f data=%h", last, prog[15][31:0]);
        end
    endtask

    task automatic test_stop_hold();
        do_reset();
        fill_halt();
        prog[0] = w_drive(32'h77, 1'b1, 1'b1);
        prog[1] = w_hold(10);
        prog[2] = w_drive(32'h88, 1'b0, 1'b0);
        load_all();
        play(5, 60, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stop_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_q.size() != 6 || obs_q[5].data !== 32'h77 || obs_q[5].done !== 1'b1 || obs_q[5].busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_freeze: got %0d cycles, want 6 ending data=77 done=1 busy=0", obs_q.size());
        end
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL start_stop_halted: got busy=%b done=%b want 0 1", busy, done);
        end
        play(-1, 60, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL replay_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (obs_q[0].done !== 1'b0 || obs_q[0].pc !== 4'd0) begin
            n_bad++;
            $display("FAIL replay_restart: got done=%b pc=%0d want 0 0", obs_q[0].done, obs_q[0].pc);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t o;
        do_reset();
        fill_halt();
        prog[0] = w_drive(32'h10, 1'b0, 1'b0);
        prog[1] = w_drive(32'h11, 1'b1, 1'b0);
        prog[2] = w_jump(0, 5);
        load_all();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        load_en = 1'b1; load_addr = 4'd0; load_word = w_drive(32'hDEAD, 1'b1, 1'b1);
        @(posedge clk); #1;
        load_en = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_before_reset: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        o = {out_data, out_disp, out_obs, step, pc, busy, done, wrap_err};
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %h want 0", o);
        end
        n_cmp++;
        if (dut.state_q !== IDLE || dut.loop_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d/%b want IDLE/0", dut.state_q, dut.loop_active);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_data = '0; m_disp = 1'b0; m_obs = 1'b0;
        play(-1, 80, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL post_reset_trace cyc %0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int r, stop_at;
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int i = 0; i < 16; i++) begin
                r = $urandom_range(0, 9);
                if (r < 5)      prog[i] = w_drive($urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                else if (r < 7) prog[i] = w_hold($urandom_range(0, 4));
                else if (r < 9) prog[i] = w_jump($urandom_range(0, 15), $urandom_range(0, 3));
                else            prog[i] = w_halt();
            end
            load_all();
            stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
            play(stop_at, 120, 1'b1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL random_trace prog %0d cyc %0d: got %h want %h", p, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_drive();
        test_hold();
        test_loop();
        test_wrap();
        test_stop_hold();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
